// File: rtl/muldiv_module.sv
// muldiv_module: iterative RV32M/RV64M multiply/divide unit that produces one result bit per cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module muldiv_module #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            muldiv_input_valid,
    output logic            muldiv_input_ready,
    input  logic [2:0]      muldiv_input_op,
    input  logic [XLEN-1:0] muldiv_input_a,
    input  logic [XLEN-1:0] muldiv_input_b,
    input  logic            muldiv_input_flush,
    output logic            muldiv_output_valid,
    input  logic            muldiv_output_ready,
    output logic [XLEN-1:0] muldiv_output_result,
    output logic            muldiv_output_busy,
    output logic [1:0]      muldiv_debug_state
);
    // Handshake: input transfers on an edge with input_valid && input_ready && !flush;
    // output transfers on an edge with output_valid && output_ready; valid never drops
    // before its transfer except on reset or flush.
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                a_neg_q;
    logic                b_neg_q;
    logic                div0_q;
    logic                ovf_q;
    logic                fix_wait_q;
    logic                valid_q;
    logic [XLEN-1:0]     result_q;

    // Operand decode, only consumed on the accept edge.
    logic                in_is_div;
    logic                in_a_signed;
    logic                in_b_signed;
    logic                in_a_neg;
    logic                in_b_neg;
    logic [XLEN-1:0]     in_abs_a;
    logic [XLEN-1:0]     in_abs_b;
    logic                in_div0;
    logic                in_ovf;
    logic                in_fast;
    logic                in_skip;
    logic                accept;

    always_comb begin
        in_is_div   = muldiv_input_op[2];
        in_a_signed = (muldiv_input_op == 3'd1) || (muldiv_input_op == 3'd2) ||
                      (muldiv_input_op == 3'd4) || (muldiv_input_op == 3'd6);
        in_b_signed = (muldiv_input_op == 3'd1) || (muldiv_input_op == 3'd4) ||
                      (muldiv_input_op == 3'd6);
        in_a_neg    = in_a_signed && muldiv_input_a[XLEN-1];
        in_b_neg    = in_b_signed && muldiv_input_b[XLEN-1];
        in_abs_a    = in_a_neg ? (~muldiv_input_a + 1'b1) : muldiv_input_a;
        in_abs_b    = in_b_neg ? (~muldiv_input_b + 1'b1) : muldiv_input_b;
        in_div0     = in_is_div && (muldiv_input_b == '0);
        in_ovf      = in_is_div && !muldiv_input_op[0] &&
                      (muldiv_input_a == MIN_VAL) && (muldiv_input_b == '1);
`ifdef MULDIV_FAST_MUL_EN
        in_fast     = !in_is_div;
`else
        in_fast     = 1'b0;
`endif
        in_skip     = in_div0 || in_ovf || in_fast;
        accept      = (state_q == S_IDLE) && muldiv_input_valid && !muldiv_input_flush;
    end

    // One iteration of shift-add multiply and restoring divide over prod_q.
    // Multiply: prod_q = {partial, multiplier}; divide: prod_q = {remainder, dividend/quotient}.
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next_d;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_next_d;
    logic [2*XLEN-1:0]   prod_next_d;

    always_comb begin
        mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next_d = {mul_sum, prod_q[XLEN-1:1]};
        div_shift  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, mcand_q};
        if (div_diff[XLEN]) begin
            div_next_d = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else begin
            div_next_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
        prod_next_d = op_q[2] ? div_next_d : mul_next_d;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mcand_q} * {{XLEN{1'b0}}, prod_q[XLEN-1:0]};
`endif

    // Sign correction and half/quotient/remainder selection.
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     result_d;

    always_comb begin
        prod_fix = (a_neg_q ^ b_neg_q) ? (~prod_q + 1'b1) : prod_q;
        quot_fix = (a_neg_q ^ b_neg_q) ? (~prod_q[XLEN-1:0] + 1'b1) : prod_q[XLEN-1:0];
        rem_fix  = a_neg_q ? (~prod_q[2*XLEN-1:XLEN] + 1'b1) : prod_q[2*XLEN-1:XLEN];
        result_d = '0;
        case (op_q)
            3'd0: result_d = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: result_d = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (div0_q) begin
                    result_d = '1;
                end else if (ovf_q) begin
                    result_d = MIN_VAL;
                end else begin
                    result_d = quot_fix;
                end
            end
            default: begin
                if (div0_q) begin
                    result_d = a_q;
                end else if (ovf_q) begin
                    result_d = '0;
                end else begin
                    result_d = rem_fix;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            cnt_q      <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            fix_wait_q <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= muldiv_input_op;
                        a_q     <= muldiv_input_a;
                        a_neg_q <= in_a_neg;
                        b_neg_q <= in_b_neg;
                        div0_q  <= in_div0;
                        ovf_q   <= in_ovf;
                        cnt_q   <= CNT_W'(XLEN);
                        if (in_is_div) begin
                            mcand_q <= in_abs_b;
                            prod_q  <= {{XLEN{1'b0}}, in_abs_a};
                        end else begin
                            mcand_q <= in_abs_a;
                            prod_q  <= {{XLEN{1'b0}}, in_abs_b};
                        end
                        // Shortcut ops spend two FIX cycles: one to settle the
                        // product register, one to register the selected result.
                        if (in_skip) begin
                            fix_wait_q <= 1'b1;
                            state_q    <= S_FIX;
                        end else begin
                            fix_wait_q <= 1'b0;
                            state_q    <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (muldiv_input_flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        prod_q <= prod_next_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (muldiv_input_flush) begin
                        fix_wait_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (fix_wait_q) begin
                        fix_wait_q <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
                        if (!op_q[2]) begin
                            prod_q <= fast_prod;
                        end
`endif
                    end else begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (muldiv_input_flush || muldiv_output_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign muldiv_input_ready   = (state_q == S_IDLE);
    assign muldiv_output_busy   = (state_q != S_IDLE);
    assign muldiv_output_valid  = valid_q;
    assign muldiv_output_result = result_q;
    assign muldiv_debug_state   = state_q;

endmodule
